// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU and multiply/divide op codes plus MDU latency defaults.
package cpu_pkg;

  typedef enum logic [3:0] {
    AluAdd  = 4'h0,
    AluSub  = 4'h1,
    AluAnd  = 4'h2,
    AluOr   = 4'h3,
    AluXor  = 4'h4,
    AluNor  = 4'h5,
    AluSlt  = 4'h6,
    AluSltu = 4'h7,
    AluSll  = 4'h8,
    AluSrl  = 4'h9,
    AluSra  = 4'ha,
    AluLui  = 4'hb
  } alu_op_e;

  typedef enum logic [2:0] {
    MduNone  = 3'b000,
    MduMult  = 3'b001,
    MduMultu = 3'b010,
    MduDiv   = 3'b011,
    MduDivu  = 3'b100,
    MduMthi  = 3'b101,
    MduMtlo  = 3'b110,
    MduRsvd  = 3'b111
  } mdu_op_e;

  localparam int unsigned MduMultCycles = 5;
  localparam int unsigned MduDivCycles  = 10;

endpackage

// File: rtl/mdu_core.sv
// Combinational HI/LO result generator for multiply and divide ops.
module mdu_core
  import cpu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi_next,
  output logic [31:0] lo_next
);

  logic [63:0] prod;

  always_comb begin
    hi_next = '0;
    lo_next = '0;
    prod    = '0;
    case (op)
      MduMult: begin
        prod    = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        hi_next = prod[63:32];
        lo_next = prod[31:0];
      end
      MduMultu: begin
        prod    = {32'h0, a} * {32'h0, b};
        hi_next = prod[63:32];
        lo_next = prod[31:0];
      end
      MduDiv: begin
        // The one signed overflow case is pinned explicitly rather than trusting simulator
        // or synthesis semantics for it.
        if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
          lo_next = 32'h8000_0000;
          hi_next = '0;
        end else if (b != '0) begin
          lo_next = $signed(a) / $signed(b);
          hi_next = $signed(a) % $signed(b);
        end
      end
      MduDivu: begin
        if (b != '0) begin
          lo_next = a / b;
          hi_next = a % b;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI and LO registers.
module mdu_unit
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MduMultCycles,
  parameter int unsigned DIV_CYCLES  = MduDivCycles
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] inA,
  input  logic [31:0] inB,
  input  logic [2:0]  op,
  input  logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  mdu_op_e     op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  logic [31:0] hi_next, lo_next;
  mdu_op_e     op_in;
  logic        div_by_zero;

  assign op_in       = mdu_op_e'(op);
  assign div_by_zero = (op_q == MduDiv || op_q == MduDivu) && (b_q == '0);

  mdu_core u_core (
    .op      (op_q),
    .a       (a_q),
    .b       (b_q),
    .hi_next (hi_next),
    .lo_next (lo_next)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          case (op_in)
            MduMult, MduMultu, MduDiv, MduDivu: begin
              state_d = StRun;
              busy_d  = 1'b1;
              op_d    = op_in;
              a_d     = inA;
              b_d     = inB;
              cnt_d   = (op_in == MduMult || op_in == MduMultu) ? MULT_CYCLES[15:0]
                                                                : DIV_CYCLES[15:0];
            end
            MduMthi: hi_d = inA;
            MduMtlo: lo_d = inA;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q <= 16'd1) begin
          cnt_d   = '0;
          state_d = StIdle;
          busy_d  = 1'b0;
          // Divide by zero burns the full latency but leaves HI/LO untouched.
          if (!div_by_zero) begin
            hi_d = hi_next;
            lo_d = lo_next;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= MduNone;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit with hand-computed HI/LO results.
module tb_mdu_unit;
  import cpu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] inA, inB;
  logic [2:0]  op;
  logic        start;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int n;

  mdu_unit dut (
    .clk     (clk),
    .reset_n (reset_n),
    .inA     (inA),
    .inB     (inB),
    .op      (op),
    .start   (start),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a start at a negedge; it is taken on the following rising edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    op = o; inA = a; inB = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'b000;
    inA = $urandom; inB = $urandom;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (busy && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 3'b000; inA = '0; inB = '0;
    #23;
    check_eq("reset_busy", {63'h0, busy}, 64'h0);
    check_eq("reset_hi", {32'h0, hi}, 64'h0);
    check_eq("reset_lo", {32'h0, lo}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    issue(MduMult, 32'hffff_fffe, 32'd3);
    wait_idle(n);
    check_eq("mult_busy", 64'(n), 64'd5);
    check_eq("mult_hilo", {hi, lo}, 64'hffff_ffff_ffff_fffa);

    issue(MduMultu, 32'hffff_fffe, 32'd3);
    wait_idle(n);
    check_eq("multu_busy", 64'(n), 64'd5);
    check_eq("multu_hilo", {hi, lo}, 64'h0000_0002_ffff_fffa);

    issue(MduDiv, 32'hffff_fff9, 32'd2);
    wait_idle(n);
    check_eq("div_busy", 64'(n), 64'd10);
    check_eq("div_hilo", {hi, lo}, 64'hffff_ffff_ffff_fffd);

    issue(MduDiv, 32'h8000_0000, 32'hffff_ffff);
    wait_idle(n);
    check_eq("div_ovf_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    issue(MduDivu, 32'd100, 32'd7);
    wait_idle(n);
    check_eq("divu_busy", 64'(n), 64'd10);
    check_eq("divu_hilo", {hi, lo}, 64'h0000_0002_0000_000e);

    issue(MduMthi, 32'h11, 32'h0);
    check_eq("mthi_busy", {63'h0, busy}, 64'h0);
    issue(MduMtlo, 32'h22, 32'h0);
    check_eq("mthi_mtlo_hilo", {hi, lo}, 64'h0000_0011_0000_0022);

    issue(MduRsvd, 32'hdead_beef, 32'h1);
    issue(MduNone, 32'hdead_beef, 32'h1);
    @(negedge clk);
    check_eq("rsvd_none_busy", {63'h0, busy}, 64'h0);
    check_eq("rsvd_none_hilo", {hi, lo}, 64'h0000_0011_0000_0022);

    issue(MduDivu, 32'd1234, 32'd0);
    wait_idle(n);
    check_eq("div0_busy", 64'(n), 64'd10);
    check_eq("div0_hilo", {hi, lo}, 64'h0000_0011_0000_0022);

    // mtlo during the third busy cycle of a mult must be dropped.
    issue(MduMult, 32'd2, 32'd3);
    @(negedge clk); @(negedge clk); @(negedge clk);
    check_eq("run_busy", {63'h0, busy}, 64'h1);
    check_eq("run_old_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
    op = MduMtlo; inA = 32'h55; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'b000; inA = $urandom;
    wait_idle(n);
    check_eq("ignored_busy_rest", 64'(n), 64'd2);
    check_eq("ignored_hilo", {hi, lo}, 64'h0000_0000_0000_0006);

    // Reset pulsed mid-divide: everything clears at once and no late write follows.
    issue(MduDivu, 32'd100, 32'd7);
    @(negedge clk); @(negedge clk); @(negedge clk); @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("rst_mid_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_mid_hilo", {hi, lo}, 64'h0);
    @(negedge clk);
    // Start is already presented as reset releases: must be taken on the first edge.
    reset_n = 1'b1; op = MduMthi; inA = 32'habc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'b000;
    check_eq("first_edge_mthi", {hi, lo}, 64'h0000_0abc_0000_0000);
    repeat (15) @(negedge clk);
    check_eq("rst_after_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_after_hilo", {hi, lo}, 64'h0000_0abc_0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
